// File: rtl/banco_balas_if.sv
// Spawn handshake between the fire logic (master) and the projectile pool (slave).
interface banco_balas_if #(
    parameter int unsigned W = 10
);
    logic         disparo_req;
    logic [W-1:0] disparo_xi;
    logic [W-1:0] disparo_yi;
    logic         disparo_aliada;
    logic         disparo_ack;
    logic         disparo_cheio;

    modport master (
        output disparo_req,
        output disparo_xi,
        output disparo_yi,
        output disparo_aliada,
        input  disparo_ack,
        input  disparo_cheio
    );

    modport slave (
        input  disparo_req,
        input  disparo_xi,
        input  disparo_yi,
        input  disparo_aliada,
        output disparo_ack,
        output disparo_cheio
    );
endinterface

// File: rtl/banco_balas.sv
// Pool of N projectile slots: req/ack spawn, vertical stepping on a movement tick,
// despawn at the playfield bounds or on a hit; inactive slots are parked at FORA.
module banco_balas #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 10,
    parameter int unsigned DIV   = 250000,
    parameter int unsigned PASSO = 1,
    parameter int unsigned Y_MIN = 0,
    parameter int unsigned Y_MAX = 479,
    parameter int unsigned RAIO  = 5,
    parameter int unsigned FORA  = 1000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             pausa,
    input  logic             reiniciarJogo,
    banco_balas_if.slave     disparo,
    input  logic [N-1:0]     acerto,
    output logic [N-1:0]     ativa,
    output logic [N-1:0]     aliada,
    output logic [N*W-1:0]   x_bus,
    output logic [N*W-1:0]   y_bus,
    output logic [W-1:0]     raio
);

    localparam int unsigned    CW        = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(DIV - 1);
    localparam logic [W-1:0]   FORA_W    = W'(FORA);
    localparam logic [W-1:0]   PASSO_W   = W'(PASSO);
    localparam logic [W:0]     PASSO_W1  = (W+1)'(PASSO);
    localparam logic [W:0]     LIM_CIMA  = (W+1)'(Y_MIN + PASSO);
    localparam logic [W:0]     LIM_BAIXO = (W+1)'(Y_MAX);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack_q, ack_d;
    logic [N-1:0]  ativa_q, ativa_d;
    logic [N-1:0]  aliada_q, aliada_d;
    logic [W-1:0]  x_q [N];
    logic [W-1:0]  x_d [N];
    logic [W-1:0]  y_q [N];
    logic [W-1:0]  y_d [N];

    logic          tick;
    logic          cheio;
    logic          achou;
    logic [W:0]    y_ext;

    assign tick  = !pausa && (cnt_q == CNT_MAX);
    assign cheio = &ativa_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            ativa_q  <= '0;
            aliada_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                x_q[i] <= FORA_W;
                y_q[i] <= FORA_W;
            end
        end else begin
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            ativa_q  <= ativa_d;
            aliada_q <= aliada_d;
            for (int i = 0; i < int'(N); i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        ativa_d  = ativa_q;
        aliada_d = aliada_q;
        x_d      = x_q;
        y_d      = y_q;
        achou    = 1'b0;
        y_ext    = '0;
        if (reiniciarJogo) begin
            cnt_d    = '0;
            ativa_d  = '0;
            aliada_d = '0;
            for (int i = 0; i < int'(N); i++) begin
                x_d[i] = FORA_W;
                y_d[i] = FORA_W;
            end
        end else begin
            if (!pausa) begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
            end
            // Hit beats movement; bounds are compared one bit wider so nothing wraps.
            for (int i = 0; i < int'(N); i++) begin
                if (ativa_q[i]) begin
                    y_ext = {1'b0, y_q[i]};
                    if (acerto[i]) begin
                        ativa_d[i] = 1'b0;
                        x_d[i]     = FORA_W;
                        y_d[i]     = FORA_W;
                    end else if (tick) begin
                        if (aliada_q[i] ? (y_ext < LIM_CIMA) : (y_ext + PASSO_W1 > LIM_BAIXO)) begin
                            ativa_d[i] = 1'b0;
                            x_d[i]     = FORA_W;
                            y_d[i]     = FORA_W;
                        end else if (aliada_q[i]) begin
                            y_d[i] = y_q[i] - PASSO_W;
                        end else begin
                            y_d[i] = y_q[i] + PASSO_W;
                        end
                    end
                end
            end
            // Target chosen from registered ativa, so a slot freed this edge waits a cycle.
            if (disparo.disparo_req && !pausa && !ack_q && !cheio) begin
                ack_d = 1'b1;
                for (int i = 0; i < int'(N); i++) begin
                    if (!ativa_q[i] && !achou) begin
                        achou       = 1'b1;
                        ativa_d[i]  = 1'b1;
                        aliada_d[i] = disparo.disparo_aliada;
                        x_d[i]      = disparo.disparo_xi;
                        y_d[i]      = disparo.disparo_yi;
                    end
                end
            end
        end
    end

    always_comb begin
        x_bus = '0;
        y_bus = '0;
        for (int i = 0; i < int'(N); i++) begin
            x_bus[i*W +: W] = x_q[i];
            y_bus[i*W +: W] = y_q[i];
        end
        ativa                 = ativa_q;
        aliada                = aliada_q;
        raio                  = W'(RAIO);
        disparo.disparo_ack   = ack_q;
        disparo.disparo_cheio = cheio;
    end

endmodule

// File: tb/tb_banco_balas.sv
// Directed bench for banco_balas with DIV=4: spawn, bounds, full pool, pause, restart, reset.
module tb_banco_balas;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        pausa;
    logic        reiniciarJogo;
    logic [3:0]  acerto;
    logic [3:0]  ativa;
    logic [3:0]  aliada;
    logic [39:0] x_bus;
    logic [39:0] y_bus;
    logic [9:0]  raio;

    int checks = 0;
    int errors = 0;

    banco_balas_if #(.W(10)) dsp ();

    banco_balas #(
        .N    (4),
        .W    (10),
        .DIV  (4),
        .PASSO(1),
        .Y_MIN(0),
        .Y_MAX(479),
        .RAIO (5),
        .FORA (1000)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .pausa        (pausa),
        .reiniciarJogo(reiniciarJogo),
        .disparo      (dsp),
        .acerto       (acerto),
        .ativa        (ativa),
        .aliada       (aliada),
        .x_bus        (x_bus),
        .y_bus        (y_bus),
        .raio         (raio)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] xs(input int i);
        return 32'(x_bus[i*10 +: 10]);
    endfunction

    function automatic logic [31:0] ys(input int i);
        return 32'(y_bus[i*10 +: 10]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic req(input logic on, input logic [9:0] x, input logic [9:0] y, input logic al);
        dsp.disparo_req    = on;
        dsp.disparo_xi     = x;
        dsp.disparo_yi     = y;
        dsp.disparo_aliada = al;
    endtask

    task automatic restart();
        reiniciarJogo = 1'b1;
        step(1);
        reiniciarJogo = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pausa = 1'b0;
        reiniciarJogo = 1'b0;
        acerto = '0;
        req(1'b0, 10'd0, 10'd0, 1'b0);
        step(2);
        chk("rst_ativa", 32'(ativa), 0);
        chk("rst_x0", xs(0), 1000);
        chk("rst_y3", ys(3), 1000);
        chk("rst_raio", 32'(raio), 5);
        chk("rst_ack", 32'(dsp.disparo_ack), 0);
        chk("rst_cheio", 32'(dsp.disparo_cheio), 0);
        reset = 1'b1;

        // Player shot, ticks at edges 4, 8, ...
        req(1'b1, 10'd100, 10'd400, 1'b1);
        step(1);
        chk("sp_ack", 32'(dsp.disparo_ack), 1);
        chk("sp_ativa", 32'(ativa), 1);
        chk("sp_x0", xs(0), 100);
        chk("sp_y0", ys(0), 400);
        req(1'b0, 10'd0, 10'd0, 1'b0);
        step(1);
        chk("sp_ack_pulse", 32'(dsp.disparo_ack), 0);
        step(2);
        chk("mv_y_e4", ys(0), 399);
        step(3);
        chk("mv_y_e7", ys(0), 399);
        step(1);
        chk("mv_y_e8", ys(0), 398);

        // Player shot reaching top bound
        restart();
        chk("rj_ativa", 32'(ativa), 0);
        chk("rj_y0", ys(0), 1000);
        req(1'b1, 10'd50, 10'd2, 1'b1);
        step(1);
        req(1'b0, 10'd0, 10'd0, 1'b0);
        chk("top_y_spawn", ys(0), 2);
        step(3);
        chk("top_y1", ys(0), 1);
        step(4);
        chk("top_y0", ys(0), 0);
        step(3);
        chk("top_still_active", 32'(ativa), 1);
        step(1);
        chk("top_gone", 32'(ativa), 0);
        chk("top_x_fora", xs(0), 1000);
        chk("top_y_fora", ys(0), 1000);

        // Enemy shot reaching bottom bound
        restart();
        req(1'b1, 10'd60, 10'd478, 1'b0);
        step(1);
        req(1'b0, 10'd0, 10'd0, 1'b0);
        step(3);
        chk("bot_y479", ys(0), 479);
        step(3);
        chk("bot_active", 32'(ativa), 1);
        chk("bot_y479_hold", ys(0), 479);
        step(1);
        chk("bot_gone", 32'(ativa), 0);
        chk("bot_y_fora", ys(0), 1000);

        // Fill the pool, then a pending request waits for a freed slot
        restart();
        req(1'b1, 10'd10, 10'd300, 1'b1);
        step(7);
        chk("full_ativa", 32'(ativa), 15);
        chk("full_cheio", 32'(dsp.disparo_cheio), 1);
        chk("full_ack4", 32'(dsp.disparo_ack), 1);
        step(1);
        chk("full_noack_e8", 32'(dsp.disparo_ack), 0);
        step(1);
        chk("full_noack_e9", 32'(dsp.disparo_ack), 0);
        chk("full_y0", ys(0), 298);
        chk("full_y2", ys(2), 299);
        chk("full_y3", ys(3), 299);
        acerto = 4'b0100;
        dsp.disparo_xi = 10'd77;
        step(1);
        acerto = '0;
        chk("hit_ativa", 32'(ativa), 11);
        chk("hit_noack", 32'(dsp.disparo_ack), 0);
        chk("hit_y2", ys(2), 1000);
        step(1);
        chk("reuse_ack", 32'(dsp.disparo_ack), 1);
        chk("reuse_ativa", 32'(ativa), 15);
        chk("reuse_x2", xs(2), 77);
        chk("reuse_y2", ys(2), 300);
        req(1'b0, 10'd0, 10'd0, 1'b0);
        step(1);
        chk("reuse_y2_tick", ys(2), 299);
        chk("reuse_y0_tick", ys(0), 297);

        // Pause freezes motion, counter and spawning but not hits
        restart();
        req(1'b1, 10'd20, 10'd200, 1'b1);
        step(1);
        req(1'b0, 10'd0, 10'd0, 1'b0);
        step(1);
        req(1'b1, 10'd30, 10'd100, 1'b0);
        step(1);
        chk("pz_two_ativa", 32'(ativa), 3);
        pausa = 1'b1;
        req(1'b1, 10'd40, 10'd50, 1'b1);
        step(10);
        chk("pz_noack", 32'(dsp.disparo_ack), 0);
        chk("pz_ativa", 32'(ativa), 3);
        chk("pz_y0", ys(0), 200);
        chk("pz_y1", ys(1), 100);
        acerto = 4'b0010;
        step(1);
        acerto = '0;
        chk("pz_hit_ativa", 32'(ativa), 1);
        chk("pz_hit_y1", ys(1), 1000);
        step(9);
        chk("pz_y0_hold", ys(0), 200);
        chk("pz_noack2", 32'(dsp.disparo_ack), 0);
        pausa = 1'b0;
        step(1);
        chk("rs_ack", 32'(dsp.disparo_ack), 1);
        chk("rs_y0", ys(0), 199);
        chk("rs_y1_nomove", ys(1), 50);
        chk("rs_x1", xs(1), 40);
        chk("rs_ativa", 32'(ativa), 3);
        req(1'b0, 10'd0, 10'd0, 1'b0);

        // Restart on a tick edge with a request present
        step(3);
        chk("pre_rj_y0", ys(0), 199);
        reiniciarJogo = 1'b1;
        req(1'b1, 10'd5, 10'd60, 1'b1);
        step(1);
        reiniciarJogo = 1'b0;
        chk("rjt_ativa", 32'(ativa), 0);
        chk("rjt_ack", 32'(dsp.disparo_ack), 0);
        chk("rjt_y0", ys(0), 1000);
        chk("rjt_x1", xs(1), 1000);
        step(1);
        req(1'b0, 10'd0, 10'd0, 1'b0);
        chk("rjt_spawn", 32'(ativa), 1);
        step(2);
        chk("rjt_y_e3", ys(0), 60);
        step(1);
        chk("rjt_y_e4", ys(0), 59);

        // Asynchronous reset mid-flight
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ativa", 32'(ativa), 0);
        chk("arst_x0", xs(0), 1000);
        chk("arst_y0", ys(0), 1000);
        step(1);
        reset = 1'b1;
        step(1);
        chk("arst_after", 32'(ativa), 0);
        chk("arst_ack", 32'(dsp.disparo_ack), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
